// File: rtl/aes_kat_pkg.sv
// Shared definitions for the AES-128 known-answer BIST: FSM encoding, KAT ROM
// contents and the "no failure" sentinel.
package aes_kat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } kat_state_e;

    localparam int         KAT_ROM_DEPTH = 3;
    localparam logic [1:0] KAT_PTR_LAST  = 2'(KAT_ROM_DEPTH - 1);
    localparam logic [7:0] NO_FAIL       = 8'hFF;

    typedef struct packed {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
    } kat_vec_t;

    // FIPS-197 appendix vectors plus the all-zero vector
    localparam logic [127:0] KAT0_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KAT0_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KAT0_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KAT1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KAT1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KAT1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KAT2_PT  = 128'h0;
    localparam logic [127:0] KAT2_KEY = 128'h0;
    localparam logic [127:0] KAT2_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    function automatic logic [1:0] rom_ptr_next(input logic [1:0] ptr);
        return (ptr == KAT_PTR_LAST) ? 2'd0 : ptr + 2'd1;
    endfunction

endpackage

// File: rtl/aes_kat_rom.sv
// Combinational KAT ROM: pointer in, {plaintext, key, ciphertext} out.
module aes_kat_rom
    import aes_kat_pkg::*;
(
    input  logic [1:0] ptr_i,
    output kat_vec_t   vec_o
);

    always_comb begin
        vec_o = '0;
        case (ptr_i)
            2'd0:    vec_o = '{pt: KAT0_PT, key: KAT0_KEY, ct: KAT0_CT};
            2'd1:    vec_o = '{pt: KAT1_PT, key: KAT1_KEY, ct: KAT1_CT};
            2'd2:    vec_o = '{pt: KAT2_PT, key: KAT2_KEY, ct: KAT2_CT};
            default: vec_o = '0;
        endcase
    end

endmodule

// File: rtl/aes_kat_bist.sv
// Known-answer self-test for the pipelined aes_128 core: issues NUM_VEC vectors
// back-to-back and checks each ciphertext LATENCY cycles later.
// Define AES_KAT_CAPTURE_EN to build the fail_data capture register.
module aes_kat_bist
    import aes_kat_pkg::*;
#(
    parameter int NUM_VEC = 3,
    parameter int LATENCY = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [127:0] core_state,
    output logic [127:0] core_key,
    input  logic [127:0] core_out,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [7:0]   err_count,
    output logic [7:0]   first_fail,
    output logic [127:0] fail_data
);

    kat_state_e state_q, state_d;

    logic [7:0]   idx_q, idx_d;
    logic [1:0]   ptr_q, ptr_d;
    logic [127:0] st_q, st_d, key_q, key_d;
    logic [7:0]   err_q, err_d, ff_q, ff_d;

    // [0..LATENCY-1] track vectors in flight, [LATENCY] is a retire stage
    // that holds DRAIN one extra cycle after the last compare.
    logic [LATENCY:0]              vld_pipe_q;
    logic [LATENCY-1:0][7:0]       tag_idx_q;
    logic [LATENCY-1:0][127:0]     exp_q;

    kat_vec_t rom_vec;
    logic     issue, last, start_run, mismatch, first_hit;

    aes_kat_rom u_rom (
        .ptr_i (ptr_q),
        .vec_o (rom_vec)
    );

    assign issue     = (state_q == ST_ISSUE);
    assign last      = (idx_q == 8'(NUM_VEC - 1));
    assign start_run = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign mismatch  = vld_pipe_q[LATENCY-1] && (core_out != exp_q[LATENCY-1]);
    assign first_hit = mismatch && (ff_q == NO_FAIL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_run) state_d = ST_ISSUE;
            ST_ISSUE: if (last) state_d = ST_DRAIN;
            ST_DRAIN: if (!(|vld_pipe_q)) state_d = ST_DONE;
            ST_DONE:  if (start_run) state_d = ST_ISSUE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
        done = (state_q == ST_DONE);
        pass = (state_q == ST_DONE) && (err_q == 8'd0);
    end

    always_comb begin
        st_d  = issue ? rom_vec.pt  : '0;
        key_d = issue ? rom_vec.key : '0;
        idx_d = start_run ? 8'd0 : (issue ? idx_q + 8'd1 : idx_q);
        ptr_d = start_run ? 2'd0 : (issue ? rom_ptr_next(ptr_q) : ptr_q);
        err_d = err_q;
        ff_d  = ff_q;
        if (start_run) begin
            err_d = 8'd0;
            ff_d  = NO_FAIL;
        end else if (mismatch) begin
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
            if (first_hit)      ff_d  = tag_idx_q[LATENCY-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q      <= 8'd0;
            ptr_q      <= 2'd0;
            st_q       <= '0;
            key_q      <= '0;
            err_q      <= 8'd0;
            ff_q       <= NO_FAIL;
            vld_pipe_q <= '0;
        end else begin
            idx_q         <= idx_d;
            ptr_q         <= ptr_d;
            st_q          <= st_d;
            key_q         <= key_d;
            err_q         <= err_d;
            ff_q          <= ff_d;
            vld_pipe_q[0] <= issue;
            for (int s = 1; s <= LATENCY; s++) vld_pipe_q[s] <= vld_pipe_q[s-1];
        end
    end

    // Payload travels alongside the valid bits; it needs no reset.
    always_ff @(posedge clk) begin
        tag_idx_q[0] <= idx_q;
        exp_q[0]     <= rom_vec.ct;
        for (int s = 1; s < LATENCY; s++) begin
            tag_idx_q[s] <= tag_idx_q[s-1];
            exp_q[s]     <= exp_q[s-1];
        end
    end

`ifdef AES_KAT_CAPTURE_EN
    logic [127:0] fail_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            fail_q <= '0;
        else if (start_run) fail_q <= '0;
        else if (first_hit) fail_q <= core_out;
    end

    assign fail_data = fail_q;
`else
    assign fail_data = '0;
`endif

    assign core_state = st_q;
    assign core_key   = key_q;
    assign err_count  = err_q;
    assign first_fail = ff_q;

endmodule

// File: tb/tb_aes_kat_bist.sv
// Self-checking bench for aes_kat_bist: three instances (3, 7, 255 vectors)
// driven by a behavioural aes_128 model (lookup + LATENCY-cycle delay queue).
module tb_aes_kat_bist;

    localparam int NI  = 3;
    localparam int LAT = 20;

    function automatic int nv_of(input int g);
        case (g)
            0:       return 3;
            1:       return 7;
            default: return 255;
        endcase
    endfunction

    localparam logic [127:0] RPT [3] = '{
        128'h3243f6a8885a308d313198a2e0370734,
        128'h00112233445566778899aabbccddeeff,
        128'h0};
    localparam logic [127:0] RKEY [3] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'h000102030405060708090a0b0c0d0e0f,
        128'h0};
    localparam logic [127:0] RCT [3] = '{
        128'h3925841d02dc09fbdc118597196a0b32,
        128'h69c4e0d86a7b0430d8cdb78070b4c55a,
        128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start    [NI];
    logic         start_ok [NI];
    logic [127:0] cst [NI], ckey [NI], cout [NI], fdata [NI];
    logic         busy [NI], done [NI], pass [NI];
    logic [7:0]   errc [NI], ffail [NI];
    int           corrupt_idx [NI];
    bit           force_zero  [NI];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Reference aes_128 behaviour restricted to the known vectors.
    function automatic logic [127:0] aes_ref(input logic [127:0] p, input logic [127:0] k);
        for (int j = 0; j < 3; j++)
            if (p == RPT[j] && k == RKEY[j]) return RCT[j];
        return '0;
    endfunction

    function automatic logic [127:0] exp_fd(input int idx);
`ifdef AES_KAT_CAPTURE_EN
        return RCT[idx % 3] ^ 128'h1;
`else
        return (idx < 0) ? 128'h0 : 128'h0;
`endif
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int NV = nv_of(g);

        aes_kat_bist #(.NUM_VEC(NV), .LATENCY(LAT)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start[g]),
            .core_state (cst[g]),
            .core_key   (ckey[g]),
            .core_out   (cout[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .pass       (pass[g]),
            .err_count  (errc[g]),
            .first_fail (ffail[g]),
            .fail_data  (fdata[g])
        );

        // Cycles since the accepted start edge; seen as m after edge k+m.
        int since = 1 << 20;
        always @(posedge clk) begin
            if (rst)                          since <= 1 << 20;
            else if (start[g] && start_ok[g]) since <= 0;
            else if (since < (1 << 20))       since <= since + 1;
        end

        logic [127:0] pipe [$];
        logic [127:0] y;
        int           vi;
        initial begin
            for (int j = 0; j < LAT; j++) pipe.push_back(RCT[2]);
            cout[g] = RCT[2];
        end

        always @(negedge clk) begin
            vi = since - 1;
            y  = aes_ref(cst[g], ckey[g]);
            if (vi >= 0 && vi < NV) begin
                chk($sformatf("d%0d_pt_v%0d", g, vi), cst[g], RPT[vi % 3]);
                chk($sformatf("d%0d_key_v%0d", g, vi), ckey[g], RKEY[vi % 3]);
                if (vi == corrupt_idx[g]) y[0] = ~y[0];
            end else if (vi == NV) begin
                chk($sformatf("d%0d_pt_idle", g), cst[g], 128'h0);
            end
            pipe.push_back(y);
            if (pipe.size() > LAT) void'(pipe.pop_front());
            cout[g] <= force_zero[g] ? 128'h0 : pipe[0];
        end
    end

    task automatic chk_reset(input int g);
        chk($sformatf("rst%0d_busy", g),  {127'h0, busy[g]},  128'h0);
        chk($sformatf("rst%0d_done", g),  {127'h0, done[g]},  128'h0);
        chk($sformatf("rst%0d_pass", g),  {127'h0, pass[g]},  128'h0);
        chk($sformatf("rst%0d_err", g),   {120'h0, errc[g]},  128'h0);
        chk($sformatf("rst%0d_ff", g),    {120'h0, ffail[g]}, 128'hFF);
        chk($sformatf("rst%0d_fd", g),    fdata[g],           128'h0);
        chk($sformatf("rst%0d_st", g),    cst[g] | ckey[g],   128'h0);
    endtask

    task automatic run(input int g, input int pulse_at);
        int nv, cyc;
        nv = nv_of(g);
        repeat ($urandom_range(0, 4)) @(negedge clk);
        start[g] = 1'b1;
        start_ok[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
        start_ok[g] = 1'b0;
        cyc = 0;
        chk($sformatf("d%0d_st0_done", g), {127'h0, done[g]},  128'h0);
        chk($sformatf("d%0d_st0_busy", g), {127'h0, busy[g]},  128'h1);
        chk($sformatf("d%0d_st0_err", g),  {120'h0, errc[g]},  128'h0);
        chk($sformatf("d%0d_st0_ff", g),   {120'h0, ffail[g]}, 128'hFF);
        chk($sformatf("d%0d_st0_fd", g),   fdata[g],           128'h0);
        while (done[g] !== 1'b1 && cyc < nv + LAT + 40) begin
            if (cyc == pulse_at) start[g] = 1'b1;
            @(negedge clk);
            start[g] = 1'b0;
            cyc++;
            if (cyc == 2) chk($sformatf("d%0d_midpass", g), {127'h0, pass[g]}, 128'h0);
        end
        if (done[g] !== 1'b1) chk($sformatf("d%0d_timeout", g), {127'h0, done[g]}, 128'h1);
        chk($sformatf("d%0d_done_cyc", g), 128'(cyc), 128'(nv + LAT + 2));
    endtask

    task automatic chk_result(input int g, input bit p, input int e, input int ff, input logic [127:0] fd);
        chk($sformatf("d%0d_pass", g), {127'h0, pass[g]},  {127'h0, p});
        chk($sformatf("d%0d_err", g),  {120'h0, errc[g]},  128'(e));
        chk($sformatf("d%0d_ff", g),   {120'h0, ffail[g]}, 128'(ff));
        chk($sformatf("d%0d_fd", g),   fdata[g],           fd);
    endtask

    initial begin
        int ci;
        for (int g = 0; g < NI; g++) begin
            start[g] = 1'b0;
            start_ok[g] = 1'b0;
            corrupt_idx[g] = -1;
            force_zero[g] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int g = 0; g < NI; g++) chk_reset(g);
        rst = 1'b0;
        @(negedge clk);

        // clean 3-vector run
        run(0, -1);
        chk_result(0, 1'b1, 0, 8'hFF, 128'h0);

        // vector 1 corrupted, restarted from DONE
        corrupt_idx[0] = 1;
        run(0, -1);
        chk_result(0, 1'b0, 1, 1, exp_fd(1));

        // random corruption with an ignored start pulse during DRAIN
        ci = $urandom_range(0, 2);
        corrupt_idx[0] = ci;
        run(0, $urandom_range(5, 20));
        chk_result(0, 1'b0, 1, ci, exp_fd(ci));

        // 7 vectors: ROM pointer wraps, clean then one random corruption
        run(1, -1);
        chk_result(1, 1'b1, 0, 8'hFF, 128'h0);
        ci = $urandom_range(0, 6);
        corrupt_idx[1] = ci;
        run(1, -1);
        chk_result(1, 1'b0, 1, ci, exp_fd(ci));

        // all outputs zero: error counter saturates
        force_zero[2] = 1'b1;
        run(2, -1);
        chk_result(2, 1'b0, 255, 0, 128'h0);
        force_zero[2] = 1'b0;

        // reset 10 cycles into ISSUE with a corrupted vector in flight
        corrupt_idx[2] = 0;
        @(negedge clk);
        start[2] = 1'b1;
        start_ok[2] = 1'b1;
        @(negedge clk);
        start[2] = 1'b0;
        start_ok[2] = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset(2);
        @(negedge clk);
        rst = 1'b0;
        corrupt_idx[2] = -1;
        run(2, -1);
        chk_result(2, 1'b1, 0, 8'hFF, 128'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
